// File: rtl/assoc_sim_accum_if.sv
// ---------------------------------------------------------------------------
// assoc_sim_accum_if
// Chunk-popcount stream into the associative similarity accumulator.
//
// Handshake: a beat transfers on a rising clock edge where pc_valid and
// pc_ready are both high. The producer holds pc_sum stable while pc_valid
// is high and not yet accepted. pc_ready depends only on accumulator state,
// never on pc_valid, so the producer may wait for it.
//
// Signals:
//   pc_valid  producer -> block  chunk popcount valid
//   pc_sum    producer -> block  popcount of one 16-bit chunk (legal 0..16)
//   pc_ready  block -> producer  block accepts pc_sum this cycle
//
// Modports: master (producer side), slave (accumulator side).
// ---------------------------------------------------------------------------
interface assoc_sim_accum_if;
  logic       pc_valid;
  logic [4:0] pc_sum;
  logic       pc_ready;

  modport master (
    output pc_valid,
    output pc_sum,
    input  pc_ready
  );

  modport slave (
    input  pc_valid,
    input  pc_sum,
    output pc_ready
  );
endinterface

// File: rtl/assoc_sim_accum.sv
// ---------------------------------------------------------------------------
// assoc_sim_accum
// Accumulates per-class similarity scores for a hyperdimensional-computing
// associative search. Each class score is the sum of CHUNKS_PER_CLASS chunk
// popcounts delivered over the pc stream; after every class the score is
// compared with the running best, and after NUM_CLASSES classes the index
// and score of the best class are reported with a one-cycle done pulse.
//
// Parameters:
//   NUM_CLASSES       classes per query (>= 2)
//   CHUNKS_PER_CLASS  16-bit popcount chunks per class (>= 1)
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       begin (or abort and restart) a query
//   pc          chunk popcount stream (slave side)
//   busy        high in any state except IDLE
//   done        one-cycle pulse, results valid
//   best_class  index of highest-scoring class (lowest index on ties)
//   best_score  score of best_class
//   state_dbg   current FSM state encoding (IDLE=0 ACCUM=1 COMPARE=2 DONE=3)
//   thresh      score threshold            (only with ASSOC_THRESH_EN)
//   hit         best_score >= thresh       (only with ASSOC_THRESH_EN)
//
// Optional feature macro: ASSOC_THRESH_EN adds the thresh input and the hit
// output. hit rises in the DONE cycle and holds until start or reset.
// ---------------------------------------------------------------------------
module assoc_sim_accum #(
  parameter  int NUM_CLASSES      = 4,
  parameter  int CHUNKS_PER_CLASS = 4,
  localparam int ACC_W            = $clog2(16 * CHUNKS_PER_CLASS + 1),
  localparam int CLASS_W          = $clog2(NUM_CLASSES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  assoc_sim_accum_if.slave    pc,
  output logic                busy,
  output logic                done,
  output logic [CLASS_W-1:0]  best_class,
  output logic [ACC_W-1:0]    best_score,
  output logic [1:0]          state_dbg
`ifdef ASSOC_THRESH_EN
  ,
  input  logic [ACC_W-1:0]    thresh,
  output logic                hit
`endif
);

  // A single chunk counter bit is kept even when there is only one chunk per
  // class so the counter never collapses to a zero-width vector.
  localparam int CHUNK_W = (CHUNKS_PER_CLASS > 1) ? $clog2(CHUNKS_PER_CLASS) : 1;

  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS_PER_CLASS - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [ACC_W-1:0]   CHUNK_MAX  = ACC_W'(16);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [ACC_W-1:0]     acc, acc_n;
  logic [CHUNK_W-1:0]   chunk_cnt, chunk_n;
  logic [CLASS_W-1:0]   class_cnt, class_n;
  logic [ACC_W-1:0]     best_score_n;
  logic [CLASS_W-1:0]   best_class_n;
  logic [ACC_W-1:0]     sum_clamped;
`ifdef ASSOC_THRESH_EN
  logic                 hit_n;
`endif

  // Out-of-range popcounts are clamped to a full chunk. With every chunk
  // capped at 16 the accumulator width can hold the largest possible class
  // score, so it cannot wrap.
  assign sum_clamped = (pc.pc_sum > 5'd16) ? CHUNK_MAX : ACC_W'(pc.pc_sum);

  assign pc.pc_ready = (state == ACCUM);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign state_dbg   = state;

  // Next-state and datapath update. start wins over everything, including a
  // beat offered in the same cycle.
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    chunk_n      = chunk_cnt;
    class_n      = class_cnt;
    best_score_n = best_score;
    best_class_n = best_class;
`ifdef ASSOC_THRESH_EN
    hit_n        = hit;
`endif

    if (start) begin
      state_n      = ACCUM;
      acc_n        = '0;
      chunk_n      = '0;
      class_n      = '0;
      best_score_n = '0;
      best_class_n = '0;
`ifdef ASSOC_THRESH_EN
      hit_n        = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_n = IDLE;
        end

        ACCUM: begin
          if (pc.pc_valid) begin
            acc_n = acc + sum_clamped;
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_n = '0;
              state_n = COMPARE;
            end else begin
              chunk_n = chunk_cnt + CHUNK_W'(1);
            end
          end
        end

        COMPARE: begin
          // Strict greater-than keeps the lower index on a tie; the first
          // class always seeds the best.
          if ((class_cnt == '0) || (acc > best_score)) begin
            best_score_n = acc;
            best_class_n = class_cnt;
          end
          if (class_cnt == LAST_CLASS) begin
            state_n = DONE;
`ifdef ASSOC_THRESH_EN
            hit_n   = (best_score_n >= thresh);
`endif
          end else begin
            class_n = class_cnt + CLASS_W'(1);
            acc_n   = '0;
            state_n = ACCUM;
          end
        end

        DONE: begin
          state_n = IDLE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      chunk_cnt  <= '0;
      class_cnt  <= '0;
      best_score <= '0;
      best_class <= '0;
`ifdef ASSOC_THRESH_EN
      hit        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      chunk_cnt  <= chunk_n;
      class_cnt  <= class_n;
      best_score <= best_score_n;
      best_class <= best_class_n;
`ifdef ASSOC_THRESH_EN
      hit        <= hit_n;
`endif
    end
  end

endmodule

// File: doc/assoc_sim_accum.md
ASSOC_SIM_ACCUM -- requirements
Module: assoc_sim_accum

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4, number of stored class hypervectors per query (>=2).
REQ-002 SHALL have parameter CHUNKS_PER_CLASS, default 4, 16-bit popcount chunks per class (>=1).
REQ-003 SHALL derive ACC_W = clog2(16*CHUNKS_PER_CLASS+1) (default 7) and CLASS_W = clog2(NUM_CLASSES) (default 2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin new query; clears accumulator, counters, best.
REQ-007 pc_valid  in  1  chunk popcount valid.
REQ-008 pc_sum  in  5  popcount of one 16-bit chunk from the upstream 16-bit tree adder (legal 0..16).
REQ-009 pc_ready  out  1  block accepts pc_sum this cycle.
REQ-010 busy  out  1  high in any state except IDLE.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 best_class  out  CLASS_W  index of class with highest score.
REQ-013 best_score  out  ACC_W  score of best_class.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM, COMPARE, DONE.
REQ-015 IDLE: pc_ready=0; start -> ACCUM with acc=0, chunk_cnt=0, class_cnt=0, best_score=0, best_class=0.
REQ-016 ACCUM: pc_ready=1; beat accepted when pc_valid&&pc_ready; acc += pc_sum, chunk_cnt++.
REQ-017 pc_sum >16 SHALL be clamped to 16 before accumulation; acc never wraps.
REQ-018 Beat accepted with chunk_cnt==CHUNKS_PER_CLASS-1 -> COMPARE, chunk_cnt=0; acc includes that beat.
REQ-019 COMPARE (exactly 1 cycle, pc_ready=0): if class_cnt==0 or acc>best_score, best_score<=acc, best_class<=class_cnt; ties keep lower index.
REQ-020 COMPARE exit: class_cnt==NUM_CLASSES-1 -> DONE; else class_cnt++, acc=0 -> ACCUM.
REQ-021 DONE: done=1 for one cycle, then IDLE; best_class/best_score hold until next start.
REQ-022 pc_valid low in ACCUM SHALL stall without state change (no timeout).
REQ-023 start in any non-IDLE state SHALL abort and restart the query as REQ-015 on the next edge; start takes priority over a simultaneous beat.
REQ-024 pc_valid outside ACCUM SHALL be ignored.
REQ-025 Latency: done asserts 2 cycles after the final accepted beat (COMPARE, DONE).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, pc_ready=0, busy=0, done=0, best_class=0, best_score=0, acc=0, all counters 0.
REQ-027 Reset mid-query SHALL discard partial results; no done pulse follows.

Configuration
REQ-028 Macro ASSOC_THRESH_EN defined: adds input thresh (ACC_W) and output hit (1); hit=1 in DONE cycle and held iff best_score>=thresh, cleared by start/reset.
REQ-029 Macro ASSOC_THRESH_EN undefined: thresh and hit ports absent; all other behaviour identical.

Verification
REQ-030 Defaults, pc_valid held high, class scores 10,40,25,5 (chunks e.g. 4,4,1,1 / 16,16,4,4 ...) -> done 2 cycles after 16th beat, best_class=1, best_score=40.
REQ-031 Scores 30,30,12,30 -> best_class=0, best_score=30 (tie keeps lowest).
REQ-032 pc_sum=31 on every beat -> each class scores 64, best_score=64, best_class=0.
REQ-033 pc_valid toggled 1/0 each cycle -> same result as REQ-030, done delayed accordingly; no beats lost during COMPARE.
REQ-034 start pulsed after 6 beats, then full query of REQ-030 -> single done, results of second query only; rst_n low mid-query -> all outputs 0, no done.
REQ-035 ASSOC_THRESH_EN, thresh=40 with REQ-030 stimulus -> hit=1; thresh=41 -> hit=0.
